// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, the canonical NOP encoding and the
// {pc, instr} record carried from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Clear wins over push/pop, and a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int EW    = $bits(fetch_entry_t)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [EW-1:0] wr_data,
  input  logic          pop,
  output logic [EW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Invalid head reads as zero so decode never sees stale buffer contents.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = fetch_entry_t'(wr_data);
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited imem requests and
// buffers in-order responses for decode; redirect flushes and squashes in-flight data.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  import riscv_pkg::fetch_entry_t;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 1;
  localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    head, push_entry;
  logic            pop, push, req_fire, rsp_fire, rsp_drop;
  logic [UW-1:0]   credit_used;
  logic [XLEN-1:0] target;

  assign target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign if_valid = !fifo_empty;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign pop      = if_valid && if_ready;

  // Every accepted request must have a buffer slot reserved, counting the slot
  // freed by a pop this cycle (hence the combinational if_ready path).
  assign credit_used    = UW'(outstanding_q) + UW'(fifo_count) - UW'(pop);
  assign imem_req_valid = reset && !redirect && (credit_used < UW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire   = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_drop   = redirect || (drop_q != '0);
  assign push       = rsp_fire && !rsp_drop;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_d     = outstanding_q - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (rsp_fire && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= START_PC;
      rsp_pc_q      <= START_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (redirect),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifndef SYNTHESIS
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rsp_valid && (outstanding_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_full && !pop));
  a_drop_bounded: assert property (@(posedge clk) disable iff (!reset)
    drop_q <= outstanding_q);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory model plus an
// expected-PC scoreboard, a redirect vector table and hand-written corner sequences.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          lat;
  } rvec_t;

  mreq_t       mq[$];
  logic [31:0] expq[$];
  logic [31:0] exp_fetch;
  int          k, cyc, checks, errors, reqs, pops;
  logic        last_req_valid, last_req_fire, last_if_valid;
  logic [31:0] last_req_addr, last_if_pc, last_if_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h5A00_00C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. The caller has already
  // driven if_ready/redirect/redirect_pc; the memory model drives the response.
  task automatic cycle();
    logic [31:0] e;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    last_req_valid = imem_req_valid;
    last_req_fire  = imem_req_valid && imem_req_ready;
    last_req_addr  = imem_req_addr;
    last_if_valid  = if_valid;
    last_if_pc     = if_pc;
    last_if_instr  = if_instr;
    if (redirect) check("no_req_on_redirect", imem_req_valid, 1'b0);
    if (last_req_fire) begin
      check("req_addr", imem_req_addr, exp_fetch);
      mq.push_back('{imem_req_addr, cyc + k});
      expq.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      reqs++;
    end
    if (if_valid && if_ready) begin
      $display("pop   pc=%h instr=%h", if_pc, if_instr);
      pops++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h required no instruction", if_pc);
      end else begin
        e = expq.pop_front();
        check("if_pc", if_pc, e);
        check("if_instr", if_instr, instr_of(e));
      end
    end
    if (redirect) begin
      expq.delete();
      exp_fetch = redirect_pc & ~32'd3;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Core and memory reset together: pending responses vanish.
  task automatic do_reset();
    reset          = 1'b0;
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    expq.delete();
    exp_fetch = RESET_PC;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  rvec_t vt[4];
  int    got, n0;

  initial begin
    vt[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 1};
    vt[1] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 3};
    vt[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 2};
    vt[3] = '{32'h0000_1235, 32'h0000_1234, 32'h0000_1238, 1};

    checks = 0; errors = 0; reqs = 0; pops = 0; cyc = 0; k = 1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    exp_fetch      = RESET_PC;
    reset          = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);

    // Streaming after release: one request and, two cycles later, one instruction per cycle
    do_reset();
    k = 1; if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("thru_req_valid", last_req_valid, 1'b1);
      check("thru_if_valid", last_if_valid, (i >= 2) ? 1'b1 : 1'b0);
      if (i >= 2) check("thru_if_pc", last_if_pc, 32'(i - 2) * 32'd4);
    end

    // Decode stalled: credit caps requests at 2, head holds pc 0 stable
    do_reset();
    k = 1; if_ready = 1'b0; n0 = reqs;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i >= 2) begin
        check("stall_head_pc", last_if_pc, 32'h0);
        check("stall_head_instr", last_if_instr, instr_of(32'h0));
      end
    end
    check("stall_req_count", 32'(reqs - n0), 32'd2);
    check("stall_req_valid", last_req_valid, 1'b0);
    if_ready = 1'b1;
    cycle();
    check("stall_pop_frees_credit", last_req_valid, 1'b1);
    repeat (4) cycle();

    // Redirect with two requests in flight (k=3): stale responses are dropped
    do_reset();
    k = 3; if_ready = 1'b1;
    repeat (2) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    check("inflight_credit_full", last_req_valid, 1'b0);
    redirect = 1'b0;
    n0 = pops;
    repeat (12) cycle();
    check("redirect_pops", (pops > n0) ? 32'd1 : 32'd0, 32'd1);

    // Redirect coinciding with a response and a pop
    do_reset();
    k = 1; if_ready = 1'b1;
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    cycle();
    redirect = 1'b0;
    cycle();
    check("flush_if_valid", last_if_valid, 1'b0);
    check("flush_req_valid", last_req_valid, 1'b1);
    check("flush_req_addr", last_req_addr, 32'h0000_0040);
    repeat (4) cycle();

    // Redirect vector table: alignment masking and PC wrap
    for (int i = 0; i < 4; i++) begin
      k = vt[i].lat; if_ready = 1'b1;
      repeat (3) cycle();
      redirect = 1'b1; redirect_pc = vt[i].rpc;
      cycle();
      redirect = 1'b0;
      got = 0;
      for (int c = 0; c < 12 && got < 2; c++) begin
        cycle();
        if (last_req_fire) begin
          if (got == 0) check("redir_first_addr", last_req_addr, vt[i].exp1);
          else          check("redir_next_addr", last_req_addr, vt[i].exp2);
          got++;
        end
      end
      check("redir_req_count", 32'(got), 32'd2);
      repeat (4) cycle();
    end

    // Asynchronous reset mid-stream with the buffer full
    do_reset();
    k = 1; if_ready = 1'b0;
    repeat (4) cycle();
    check("full_before_reset", last_if_valid, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("async_if_valid", if_valid, 1'b0);
    check("async_if_pc", if_pc, 32'h0);
    check("async_if_instr", if_instr, 32'h0);
    check("async_req_valid", imem_req_valid, 1'b0);
    check("async_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    do_reset();
    if_ready = 1'b1;
    cycle();
    check("restart_req_addr", last_req_addr, RESET_PC);
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
